// File: rtl/cosim_manifest_pkg.sv
// Shared types and helpers for the cosim manifest server: FSM state
// encoding, word/address geometry and the zero-filling word assembler.
package cosim_manifest_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_e;

    localparam int WORD_BYTES = 8;
    localparam int ADDR_W     = 33;

    // Builds one little-endian 64-bit word. window[k] is the array byte
    // fetched for address addr+k; any byte whose address lies at or past
    // size is forced to 0x00, so reads beyond the manifest return zeros.
    function automatic logic [63:0] assemble_word(
        input logic [ADDR_W-1:0]               addr,
        input logic [ADDR_W-1:0]               size,
        input logic [WORD_BYTES-1:0][7:0]      window
    );
        logic [63:0]       word;
        logic [ADDR_W-1:0] byte_addr;
        word = '0;
        for (int k = 0; k < WORD_BYTES; k++) begin
            byte_addr = addr + ADDR_W'(k);
            if (byte_addr < size) begin
                word[8*k +: 8] = window[k];
            end
        end
        return word;
    endfunction

endpackage

// File: rtl/cosim_rr_arb2.sv
// Two-way round-robin arbiter. The favoured requester is held in r_prio;
// after an accepted grant the pointer moves to the requester that was
// not served, so a continuously requesting port wins at least every
// other arbitration.
module cosim_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant,
    output logic       grant_idx
);

    logic r_prio;
    logic w_other;

    assign w_other = ~r_prio;

    // Grant the favoured requester if it asks, otherwise the other one.
    always_comb begin
        grant     = 2'b00;
        grant_idx = r_prio;
        if (req[r_prio]) begin
            grant[r_prio] = 1'b1;
            grant_idx     = r_prio;
        end else if (req[w_other]) begin
            grant[w_other] = 1'b1;
            grant_idx      = w_other;
        end
    end

    // Pointer moves only when the granted request is actually taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio <= 1'b0;
        end else if (advance) begin
            r_prio <= ~grant_idx;
        end
    end

endmodule

// File: rtl/cosim_manifest_server.sv
// Serves the compressed manifest byte array to two readers. Burst requests
// (byte offset + word count) are arbitrated round-robin and answered as a
// stream of 64-bit little-endian words tagged with the requester ID.
//
// Handshake: a transfer happens on any cycle where valid and ready are both
// high at the rising edge; valid never waits on ready, and while valid is
// high without ready the payload (rsp_data/rsp_id/rsp_last) holds steady.
module cosim_manifest_server
    import cosim_manifest_pkg::*;
#(
    parameter int MANIFEST_SIZE = 64,
    parameter int LEN_W         = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [MANIFEST_SIZE-1:0][7:0] manifest,
    input  logic [1:0]                    req_valid,
    output logic [1:0]                    req_ready,
    input  logic [1:0][31:0]              req_offset,
    input  logic [1:0][LEN_W-1:0]         req_words,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [63:0]                   rsp_data,
    output logic                          rsp_id,
    output logic                          rsp_last,
    output logic                          busy
);

    localparam int                IDX_W  = (MANIFEST_SIZE > 1) ? $clog2(MANIFEST_SIZE) : 1;
    localparam logic [ADDR_W-1:0] SIZE_A = ADDR_W'(MANIFEST_SIZE);

    state_e                      r_state;
    logic [ADDR_W-1:0]           r_addr;
    logic [LEN_W-1:0]            r_remain;
    logic                        r_id;
    logic [63:0]                 r_data;
    logic                        r_last;

    logic [1:0]                  w_grant;
    logic                        w_grant_idx;
    logic                        w_idle;
    logic                        w_accept;
    logic                        w_beat;
    logic [31:0]                 w_sel_offset;
    logic [LEN_W-1:0]            w_sel_words;
    logic [ADDR_W-1:0]           w_fetch_addr;
    logic [WORD_BYTES-1:0][7:0]  w_window;
    logic [63:0]                 w_word;

    cosim_rr_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid),
        .advance   (w_accept),
        .grant     (w_grant),
        .grant_idx (w_grant_idx)
    );

    // Requests are only offered in IDLE and never while reset is applied.
    assign w_idle       = (r_state == IDLE) && !rst;
    assign req_ready    = w_idle ? w_grant : 2'b00;
    assign w_accept     = |(req_valid & req_ready);
    assign w_beat       = (r_state == STREAM) && rsp_ready;

    assign w_sel_offset = req_offset[w_grant_idx];
    assign w_sel_words  = req_words[w_grant_idx];

    // The word to load next: the request offset when starting a burst,
    // otherwise the word following the one currently presented.
    assign w_fetch_addr = (r_state == IDLE) ? {1'b0, w_sel_offset}
                                            : r_addr + ADDR_W'(WORD_BYTES);

    // Fetch the eight candidate bytes; out-of-range lanes use index 0 and
    // are zeroed by the assembler, so the array is never indexed past its end.
    for (genvar k = 0; k < WORD_BYTES; k++) begin : g_win
        logic [ADDR_W-1:0] w_byte_addr;
        logic [IDX_W-1:0]  w_idx;
        assign w_byte_addr = w_fetch_addr + ADDR_W'(k);
        assign w_idx       = (w_byte_addr < SIZE_A) ? w_byte_addr[IDX_W-1:0] : '0;
        assign w_window[k] = manifest[w_idx];
    end

    assign w_word = assemble_word(w_fetch_addr, SIZE_A, w_window);

    // Burst FSM: latches a request on accept, then walks the address and
    // count once per accepted beat, loading the next word into the
    // response register so it appears the cycle after the handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_addr   <= '0;
            r_remain <= '0;
            r_id     <= 1'b0;
            r_data   <= '0;
            r_last   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_addr   <= w_fetch_addr;
                        r_remain <= w_sel_words;
                        r_id     <= w_grant_idx;
                        r_data   <= w_word;
                        r_last   <= (w_sel_words == LEN_W'(1));
                        // A zero-length request is consumed without a response.
                        if (w_sel_words != '0) begin
                            r_state <= STREAM;
                        end
                    end
                end
                STREAM: begin
                    if (w_beat) begin
                        r_addr   <= w_fetch_addr;
                        r_remain <= r_remain - LEN_W'(1);
                        r_data   <= w_word;
                        r_last   <= (r_remain == LEN_W'(2));
                        if (r_last) begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rsp_valid = (r_state == STREAM);
    assign busy      = (r_state == STREAM);
    assign rsp_data  = r_data;
    assign rsp_id    = r_id;
    assign rsp_last  = r_last;

endmodule
